// File: rtl/rom_display_sequencer_pkg.sv
// Shared types and constants for the ROM-to-display sequencer.
// Holds the FSM state encoding, the blank display code and the prescaler width helper.
package rom_disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // 8'hFF decodes to blank on both BCD digits
    localparam logic [7:0] DISP_BLANK = 8'hFF;

    function automatic int clog2(input int value);
        int width;
        int remaining;
        width     = 32'sd0;
        remaining = value - 32'sd1;
        while (remaining > 32'sd0) begin
            width     = width + 32'sd1;
            remaining = remaining >>> 32'sd1;
        end
        return width;
    endfunction

endpackage

// File: rtl/rom_display_sequencer_if.sv
// Control, ROM and display signals of the sequencer, bundled for port connection.
interface rom_display_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              run;
    logic              step;
    logic              restart;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              wrapped;

    modport master (
        output run, step, restart, rom_data,
        input  rom_addr, disp_data, disp_valid, wrapped
    );

    modport slave (
        input  run, step, restart, rom_data,
        output rom_addr, disp_data, disp_valid, wrapped
    );

endinterface

// File: rtl/rom_display_sequencer_tick_prescaler.sv
// Free-running divider that flags the last count of a TICK_DIV period.
// Holds while disabled; clear wins over enable.
module tick_prescaler
    import rom_disp_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             CNT_W    = clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // Count register: clear, advance (wrapping at the period end) or hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else if (clr) begin
            count_r <= CNT_ZERO;
        end else if (en) begin
            count_r <= (count_r == CNT_LAST) ? CNT_ZERO : count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign tick = (count_r == CNT_LAST);

endmodule

// File: rtl/rom_display_sequencer.sv
// Walks a synchronous ROM and latches each byte into the two-digit display register.
// Advances on the prescaler tick while running, or on a step pulse while paused.
module rom_display_sequencer
    import rom_disp_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int TICK_DIV  = 50000000,
    parameter int LAST_ADDR = 2**ADDR_W - 1
) (
    input logic                    clk,
    input logic                    rst,
    rom_display_sequencer_if.slave bus
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);
    localparam logic [DATA_W-1:0] BLANK     = DATA_W'(DISP_BLANK);

    state_t            state_r;
    state_t            state_next_s;
    logic              advance_s;
    logic              capture_s;
    logic              presc_clr_s;
    logic              presc_en_s;
    logic              tick_s;
    logic [ADDR_W-1:0] rom_addr_r;
    logic [DATA_W-1:0] disp_data_r;
    logic              disp_valid_r;
    logic              wrapped_r;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr_s),
        .en   (presc_en_s),
        .tick (tick_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; restart overrides every state
    always_comb begin
        state_next_s = state_r;
        if (bus.restart) begin
            state_next_s = ADDR;
        end else begin
            case (state_r)
                IDLE:    state_next_s = (bus.run || bus.step) ? ADDR : IDLE;
                ADDR:    state_next_s = CAPTURE;
                CAPTURE: state_next_s = HOLD;
                HOLD:    state_next_s = advance_s ? ADDR : HOLD;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Control decode; step and timer expiry together still give a single advance
    always_comb begin
        advance_s   = 1'b0;
        capture_s   = 1'b0;
        presc_clr_s = bus.restart;
        presc_en_s  = 1'b0;
        if (!bus.restart) begin
            case (state_r)
                CAPTURE: begin
                    capture_s   = 1'b1;
                    presc_clr_s = 1'b1;
                end
                HOLD: begin
                    advance_s  = bus.step || (bus.run && tick_s);
                    presc_en_s = bus.run && !advance_s;
                end
                default: begin
                    advance_s = 1'b0;
                end
            endcase
        end else begin
            advance_s = 1'b0;
        end
    end

    // Address counter and wrap pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_r <= ADDR_ZERO;
            wrapped_r  <= 1'b0;
        end else if (bus.restart) begin
            rom_addr_r <= ADDR_ZERO;
            wrapped_r  <= 1'b0;
        end else if (advance_s) begin
            rom_addr_r <= (rom_addr_r == ADDR_LAST) ? ADDR_ZERO : rom_addr_r + ADDR_ONE;
            wrapped_r  <= (rom_addr_r == ADDR_LAST);
        end else begin
            rom_addr_r <= rom_addr_r;
            wrapped_r  <= 1'b0;
        end
    end

    // Display register; only CAPTURE changes it, restart leaves the old byte showing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data_r  <= BLANK;
            disp_valid_r <= 1'b0;
        end else if (capture_s) begin
            disp_data_r  <= bus.rom_data;
            disp_valid_r <= 1'b1;
        end else begin
            disp_data_r  <= disp_data_r;
            disp_valid_r <= disp_valid_r;
        end
    end

    assign bus.rom_addr   = rom_addr_r;
    assign bus.disp_data  = disp_data_r;
    assign bus.disp_valid = disp_valid_r;
    assign bus.wrapped    = wrapped_r;

endmodule

// File: doc/rom_display_sequencer.md
Name: rom_display_sequencer

Overview:
- Steps a synchronous ROM through its address space and latches each ROM byte into a register that drives the two-digit BCD seven-segment display path.
- Sits between the ROM and the dual seven-segment decoders. Owns the ROM address, the read timing and the display hold time.
- Advances on a programmable timer while running, or on a single-step pulse while paused.

Parameters:
- ADDR_W, 4: ROM address width.
- DATA_W, 8: ROM data width; two BCD nibbles.
- TICK_DIV, 50000000: clock cycles per automatic advance; must be at least 2.
- LAST_ADDR, 2**ADDR_W-1: final address before wrap to 0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = auto-advance, 0 = paused
- step  in  1  synchronous single-cycle pulse; advance one address
- restart  in  1  synchronous single-cycle pulse; return to address 0
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  DATA_W  ROM output, valid one cycle after rom_addr
- disp_data  out  DATA_W  byte presented to the display decoders
- disp_valid  out  1  1 once the first ROM byte has been captured
- wrapped  out  1  single-cycle pulse when the address wraps LAST_ADDR->0

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rom_addr=0, prescaler=0.
  - disp_data=8'hFF, which blanks both digits.
  - disp_valid=0, wrapped=0.
- States: IDLE, ADDR, CAPTURE, HOLD.
- IDLE:
  - run=1 or step=1 -> ADDR. rom_addr is unchanged, so address 0 is fetched first.
  - Otherwise stay in IDLE.
- ADDR: rom_addr is stable for one cycle while the ROM registers it; always -> CAPTURE.
- CAPTURE: disp_data<=rom_data, disp_valid<=1, prescaler<=0; always -> HOLD.
- HOLD:
  - Advance condition: step=1, or (run=1 and prescaler==TICK_DIV-1).
  - On advance: rom_addr<=rom_addr+1, wrapping LAST_ADDR->0 with wrapped=1 for that cycle; -> ADDR.
  - Else if run=1: prescaler increments.
  - Else (run=0): prescaler freezes and the display holds indefinitely.
- Timing:
  - Latency from an advance in HOLD cycle n: new rom_addr visible in cycle n+1; new disp_data visible in cycle n+3.
  - Steady-state period with run=1 and no step: TICK_DIV+2 cycles per address.
- Simultaneous step and timer expiry: exactly one advance.
- step in ADDR or CAPTURE: ignored, not queued.
- restart (any state, highest priority over step and timer):
  - rom_addr<=0, prescaler<=0, wrapped=0; -> ADDR.
  - disp_data and disp_valid are unchanged until the next CAPTURE.
- run deasserted mid-fetch: ADDR and CAPTURE still complete. The FSM then sits in HOLD with the prescaler frozen.
- Nibble values above 9 need no handling here; the decoders blank them.
- rst asserted mid-operation: immediate return to the reset values above.

Decomposition:
- Package rom_disp_pkg holds:
  - state enum (IDLE, ADDR, CAPTURE, HOLD)
  - constant DISP_BLANK = 8'hFF
  - prescaler width function clog2(TICK_DIV)
- Sub-module tick_prescaler:
  - inputs: clk, rst, clr, en
  - output: tick, asserted when count==TICK_DIV-1
  - count holds when en=0; clr has priority over en.
- FSM, address counter and display register stay in the top module.

Test Plan (TICK_DIV=4, ADDR_W=2, ROM contents {8'h12, 8'h34, 8'h56, 8'h9A}):
- Reset release with run=0, step=0 -> rom_addr=0, disp_data=8'hFF, disp_valid=0 held for 20 cycles.
- run=1 from IDLE -> disp_data sequence 12,34,56,9A,12 at a 6-cycle period; wrapped pulses once as rom_addr goes 3->0.
- run=0 with one step pulse in HOLD at cycle n -> rom_addr increments at n+1; disp_data updates at n+3; no further change for 50 cycles.
- step asserted in the same cycle as timer expiry -> exactly one increment; step pulse during CAPTURE -> ignored, address unchanged.
- restart while at address 2 in HOLD -> rom_addr=0 next cycle; disp_data stays 56 for two cycles, then becomes 12.
- rst asserted mid-ADDR -> all outputs return to their reset values asynchronously; after release with run=1 the sequence restarts at 12.
